// File: rtl/prefetcher_pkg.sv
// Shared types for the prefetcher queue front-end: queue opcodes, queue error codes,
// controller states and the block-width derivation.
package prefetcher_pkg;

   typedef enum logic [2:0] {
      OpNop   = 3'd0,
      OpInv   = 3'd1,
      OpRead  = 3'd2,
      OpWreq  = 3'd3,
      OpWresp = 3'd4
   } opcode_e;

   typedef enum logic [1:0] {
      ErrNone = 2'd0,
      ErrDup  = 2'd1,
      ErrFull = 2'd2
   } err_e;

   typedef enum logic [1:0] {
      StDisabled = 2'd0,
      StRun      = 2'd1,
      StBackoff  = 2'd2,
      StDrain    = 2'd3
   } state_e;

   // Block width in bits from log2 of the block size in bytes.
   function automatic int unsigned blk_bits(input int unsigned log_block_bytes);
      return 32'd8 << log_block_bytes;
   endfunction

endpackage

// File: rtl/prefetcher_rr_arb2.sv
// Two-requester round-robin arbiter. The requester that wins a grant loses
// priority for the next contested cycle; requester 0 is favoured after reset.
module prefetcher_rr_arb2 (
   input  logic       clk,
   input  logic       resetN,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   // 0: requester 0 favoured, 1: requester 1 favoured
   logic r_prio;

   // Grant the favoured requester when both ask, otherwise whichever asks.
   always_comb begin
      o_gnt = 2'b00;
      if (i_req[0] && (!r_prio || !i_req[1])) begin
         o_gnt[0] = 1'b1;
      end else if (i_req[1]) begin
         o_gnt[1] = 1'b1;
      end
   end

   // Hand priority to the other requester after every grant.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_prio <= 1'b0;
      end else if (o_gnt[0]) begin
         r_prio <= 1'b1;
      end else if (o_gnt[1]) begin
         r_prio <= 1'b0;
      end
   end

endmodule

// File: rtl/prefetcher_queue_ctrl.sv
// Front-end controller for the prefetcher data queue: arbitrates DRAM responses,
// invalidates, CPU lookups and prefetch issues onto the registered queue port,
// returns lookup results, counts queue errors and throttles prefetch issue.
module prefetcher_queue_ctrl
   import prefetcher_pkg::*;
#(
   parameter int unsigned LOG_QUEUE_SIZE       = 6,
   parameter int unsigned LOG_BLOCK_DATA_BYTES = 6,
   parameter int unsigned ADDR_BITS            = 64,
   parameter int unsigned BACKOFF_BITS         = 8,
   localparam int unsigned BLK_BITS            = blk_bits(LOG_BLOCK_DATA_BYTES),
   localparam int unsigned CNT_W               = LOG_QUEUE_SIZE + 1
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    dramRespValid,
   output logic                    dramRespReady,
   input  logic [ADDR_BITS-1:0]    dramRespAddr,
   input  logic [BLK_BITS-1:0]     dramRespData,
   input  logic                    invValid,
   output logic                    invReady,
   input  logic [ADDR_BITS-1:0]    invAddr,
   input  logic                    rdReqValid,
   output logic                    rdReqReady,
   input  logic [ADDR_BITS-1:0]    rdReqAddr,
   output logic                    rdRespValid,
   output logic                    rdRespHit,
   output logic [BLK_BITS-1:0]     rdRespData,
   input  logic                    pfReqValid,
   output logic                    pfReqReady,
   input  logic [ADDR_BITS-1:0]    pfReqAddr,
   output logic [ADDR_BITS-1:0]    qReqAddr,
   output logic [BLK_BITS-1:0]     qReqData,
   output logic [2:0]              qReqOpcode,
   input  logic                    qRespValid,
   input  logic [BLK_BITS-1:0]     qRespData,
   input  logic [CNT_W-1:0]        qOutstandingReqCnt,
   input  logic                    qAlmostFull,
   input  logic [1:0]              qErrorCode,
   input  logic                    crs_enable,
   input  logic [CNT_W-1:0]        crs_maxOutstanding,
   input  logic [BACKOFF_BITS-1:0] crs_backoffCycles,
   output logic [1:0]              ctrlState,
   output logic [15:0]             dupErrCnt,
   output logic [15:0]             fullErrCnt
);

   localparam logic [BACKOFF_BITS-1:0] BoOne = 1;

   state_e                  r_state, w_state_nxt;
   logic [BACKOFF_BITS-1:0] r_bo_cnt, w_bo_cnt_nxt;
   opcode_e                 r_opcode, w_op;
   logic [ADDR_BITS-1:0]    r_addr, w_addr;
   logic [BLK_BITS-1:0]     r_data, w_data;
   opcode_e                 r_tag0, r_tag1;
   logic [BLK_BITS-1:0]     r_qdata;
   logic                    r_rd_valid, r_rd_hit;
   logic [BLK_BITS-1:0]     r_rd_data;
   logic [15:0]             r_dup_cnt, r_full_cnt;

   logic       w_gnt_wresp, w_gnt_inv, w_rd_elig, w_pf_elig, w_full_err, w_dup_err;
   logic [1:0] w_arb_req, w_arb_gnt;
   logic [CNT_W:0] w_eff_out;

   // The queue's count lags by one cycle, so a WREQ sitting on the port counts now.
   assign w_eff_out = {1'b0, qOutstandingReqCnt} + {{CNT_W{1'b0}}, (r_opcode == OpWreq)};

   assign w_rd_elig = rdReqValid && (r_state != StDisabled);
   assign w_pf_elig = pfReqValid && (r_state == StRun) && !qAlmostFull &&
                      (w_eff_out < {1'b0, crs_maxOutstanding});

   // Fixed priority above the READ/PF round-robin; nothing is granted in reset.
   assign w_gnt_wresp = resetN && dramRespValid;
   assign w_gnt_inv   = resetN && invValid && !dramRespValid;
   assign w_arb_req   = {w_pf_elig, w_rd_elig} & {2{resetN && !dramRespValid && !invValid}};

   prefetcher_rr_arb2 u_rd_pf_arb (
      .clk    (clk),
      .resetN (resetN),
      .i_req  (w_arb_req),
      .o_gnt  (w_arb_gnt)
   );

   assign dramRespReady = w_gnt_wresp;
   assign invReady      = w_gnt_inv;
   assign rdReqReady    = w_arb_gnt[0];
   assign pfReqReady    = w_arb_gnt[1];

   // Select the granted command; with no grant a NOP goes out and addr/data hold.
   always_comb begin
      w_op   = OpNop;
      w_addr = r_addr;
      w_data = r_data;
      if (w_gnt_wresp) begin
         w_op   = OpWresp;
         w_addr = dramRespAddr;
         w_data = dramRespData;
      end else if (w_gnt_inv) begin
         w_op   = OpInv;
         w_addr = invAddr;
         w_data = '0;
      end else if (w_arb_gnt[0]) begin
         w_op   = OpRead;
         w_addr = rdReqAddr;
         w_data = '0;
      end else if (w_arb_gnt[1]) begin
         w_op   = OpWreq;
         w_addr = pfReqAddr;
         w_data = '0;
      end
   end

   // Register the queue command and shift its opcode down the tag pipeline.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_opcode <= OpNop;
         r_addr   <= '0;
         r_data   <= '0;
         r_tag0   <= OpNop;
         r_tag1   <= OpNop;
      end else begin
         r_opcode <= w_op;
         r_addr   <= w_addr;
         r_data   <= w_data;
         r_tag0   <= w_op;
         r_tag1   <= r_tag0;
      end
   end

   assign qReqOpcode = r_opcode;
   assign qReqAddr   = r_addr;
   assign qReqData   = r_data;

   // Lookup return: data is taken one edge after issue, hit one edge later.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_qdata    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         if (r_tag0 == OpRead) begin
            r_qdata <= qRespData;
         end
         r_rd_valid <= (r_tag1 == OpRead);
         if (r_tag1 == OpRead) begin
            r_rd_hit  <= qRespValid;
            r_rd_data <= r_qdata;
         end
      end
   end

   assign rdRespValid = r_rd_valid;
   assign rdRespHit   = r_rd_hit;
   assign rdRespData  = r_rd_data;

   // The error code belongs to the WREQ issued two edges earlier, and only to it.
   assign w_dup_err  = (r_tag1 == OpWreq) && (qErrorCode == ErrDup);
   assign w_full_err = (r_tag1 == OpWreq) && (qErrorCode == ErrFull);

   // Saturating error counters.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_dup_cnt  <= '0;
         r_full_cnt <= '0;
      end else begin
         if (w_dup_err && (r_dup_cnt != 16'hFFFF)) begin
            r_dup_cnt <= r_dup_cnt + 16'd1;
         end
         if (w_full_err && (r_full_cnt != 16'hFFFF)) begin
            r_full_cnt <= r_full_cnt + 16'd1;
         end
      end
   end

   assign dupErrCnt  = r_dup_cnt;
   assign fullErrCnt = r_full_cnt;

   // Controller next state and backoff counter.
   always_comb begin
      w_state_nxt  = r_state;
      w_bo_cnt_nxt = r_bo_cnt;
      unique case (r_state)
         StDisabled: begin
            if (crs_enable) w_state_nxt = StRun;
         end
         StRun: begin
            if (!crs_enable) begin
               w_state_nxt = StDrain;
            end else if (w_full_err) begin
               w_state_nxt  = StBackoff;
               w_bo_cnt_nxt = crs_backoffCycles;
            end
         end
         StBackoff: begin
            if (!crs_enable) begin
               w_state_nxt = StDrain;
            end else if (r_bo_cnt == '0) begin
               w_state_nxt = StRun;
            end else begin
               w_bo_cnt_nxt = r_bo_cnt - BoOne;
            end
         end
         StDrain: begin
            if (crs_enable) begin
               w_state_nxt = StRun;
            end else if ((qOutstandingReqCnt == '0) && (r_tag0 != OpWreq) &&
                         (r_tag1 != OpWreq)) begin
               w_state_nxt = StDisabled;
            end
         end
         default: w_state_nxt = StDisabled;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state  <= StDisabled;
         r_bo_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_bo_cnt <= w_bo_cnt_nxt;
      end
   end

   assign ctrlState = r_state;

endmodule

// File: tb/tb_prefetcher_queue_ctrl.sv
// Scoreboard bench for prefetcher_queue_ctrl: stimulus pushes expected queue
// commands and lookup results; a negedge monitor pops and compares them.
module tb_prefetcher_queue_ctrl;

   localparam int unsigned AW = 64;
   localparam int unsigned BW = 512;
   localparam int unsigned CW = 7;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          dramRespValid = 1'b0, dramRespReady;
   logic [AW-1:0] dramRespAddr = '0;
   logic [BW-1:0] dramRespData = '0;
   logic          invValid = 1'b0, invReady;
   logic [AW-1:0] invAddr = '0;
   logic          rdReqValid = 1'b0, rdReqReady;
   logic [AW-1:0] rdReqAddr = '0;
   logic          rdRespValid, rdRespHit;
   logic [BW-1:0] rdRespData;
   logic          pfReqValid = 1'b0, pfReqReady;
   logic [AW-1:0] pfReqAddr = '0;
   logic [AW-1:0] qReqAddr;
   logic [BW-1:0] qReqData;
   logic [2:0]    qReqOpcode;
   logic          qRespValid;
   logic [BW-1:0] qRespData;
   logic [CW-1:0] qOutstandingReqCnt = '0;
   logic          qAlmostFull = 1'b0;
   logic [1:0]    qErrorCode;
   logic          crs_enable = 1'b0;
   logic [CW-1:0] crs_maxOutstanding = 7'd8;
   logic [7:0]    crs_backoffCycles = 8'd5;
   logic [1:0]    ctrlState;
   logic [15:0]   dupErrCnt, fullErrCnt;

   typedef struct {
      logic [2:0]    op;
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
      bit            chk_data;
   } cmd_t;

   typedef struct {
      logic          hit;
      logic [BW-1:0] data;
   } rd_t;

   cmd_t       exp_cmd[$];
   rd_t        exp_rd[$];
   logic       hit_q[$];
   logic [1:0] err_q[$];

   int n_vec = 0;
   int n_err = 0;

   prefetcher_queue_ctrl dut (
      .clk                (clk),
      .resetN             (resetN),
      .dramRespValid      (dramRespValid),
      .dramRespReady      (dramRespReady),
      .dramRespAddr       (dramRespAddr),
      .dramRespData       (dramRespData),
      .invValid           (invValid),
      .invReady           (invReady),
      .invAddr            (invAddr),
      .rdReqValid         (rdReqValid),
      .rdReqReady         (rdReqReady),
      .rdReqAddr          (rdReqAddr),
      .rdRespValid        (rdRespValid),
      .rdRespHit          (rdRespHit),
      .rdRespData         (rdRespData),
      .pfReqValid         (pfReqValid),
      .pfReqReady         (pfReqReady),
      .pfReqAddr          (pfReqAddr),
      .qReqAddr           (qReqAddr),
      .qReqData           (qReqData),
      .qReqOpcode         (qReqOpcode),
      .qRespValid         (qRespValid),
      .qRespData          (qRespData),
      .qOutstandingReqCnt (qOutstandingReqCnt),
      .qAlmostFull        (qAlmostFull),
      .qErrorCode         (qErrorCode),
      .crs_enable         (crs_enable),
      .crs_maxOutstanding (crs_maxOutstanding),
      .crs_backoffCycles  (crs_backoffCycles),
      .ctrlState          (ctrlState),
      .dupErrCnt          (dupErrCnt),
      .fullErrCnt         (fullErrCnt)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
      return {8{a}};
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue model: read data follows the driven address, hit and error codes
   // appear one edge after the command so the DUT samples them two edges after accept.
   assign qRespData = (qReqOpcode == 3'd2) ? blk(qReqAddr) : '0;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         qRespValid <= 1'b0;
         qErrorCode <= 2'd0;
      end else begin
         qRespValid <= 1'b0;
         qErrorCode <= 2'd0;
         if (qReqOpcode == 3'd2) qRespValid <= (hit_q.size() > 0) ? hit_q.pop_front() : 1'b1;
         if (qReqOpcode == 3'd3 && err_q.size() > 0) qErrorCode <= err_q.pop_front();
      end
   end

   // Monitor: every non-NOP queue command and every lookup result is scored.
   always @(negedge clk) begin
      if (resetN) begin
         if (qReqOpcode != 3'd0) begin
            if (exp_cmd.size() == 0) begin
               check("unexpected_cmd", {509'd0, qReqOpcode}, '0);
            end else begin
               cmd_t c;
               c = exp_cmd.pop_front();
               check("cmd_op_addr", {445'd0, qReqOpcode, qReqAddr}, {445'd0, c.op, c.addr});
               if (c.chk_data) check("cmd_data", qReqData, c.data);
            end
         end
         if (rdRespValid) begin
            if (exp_rd.size() == 0) begin
               check("unexpected_rdresp", {511'd0, rdRespValid}, '0);
            end else begin
               rd_t r;
               r = exp_rd.pop_front();
               check("rd_hit", {511'd0, rdRespHit}, {511'd0, r.hit});
               check("rd_data", rdRespData, r.data);
            end
         end
      end
   end

   // Check the readies one-hot {wresp, inv, rd, pf} and queue the expected results.
   task automatic grant_step(input string name, input logic [3:0] exp_rdy, input logic hit);
      cmd_t c;
      rd_t  r;
      #1;
      check(name, {508'd0, dramRespReady, invReady, rdReqReady, pfReqReady}, {508'd0, exp_rdy});
      c.chk_data = 1'b0;
      c.data     = '0;
      if (exp_rdy[3]) begin
         c.op = 3'd4; c.addr = dramRespAddr; c.data = dramRespData; c.chk_data = 1'b1;
      end else if (exp_rdy[2]) begin
         c.op = 3'd1; c.addr = invAddr;
      end else if (exp_rdy[1]) begin
         c.op = 3'd2; c.addr = rdReqAddr;
         r.hit = hit; r.data = blk(rdReqAddr);
         exp_rd.push_back(r);
         hit_q.push_back(hit);
      end else begin
         c.op = 3'd3; c.addr = pfReqAddr;
      end
      exp_cmd.push_back(c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      bit done;
      cmd_t c;

      // Reset: nothing is granted while resetN is low.
      repeat (2) @(negedge clk);
      dramRespValid = 1'b1;
      #1 check("ready_in_reset", {511'd0, dramRespReady}, '0);
      dramRespValid = 1'b0;
      @(negedge clk) resetN = 1'b1;
      @(negedge clk);
      check("rst_opcode", {509'd0, qReqOpcode}, '0);
      check("rst_addr", {448'd0, qReqAddr}, '0);
      check("rst_data", qReqData, '0);
      check("rst_rdvalid", {511'd0, rdRespValid}, '0);
      check("rst_rdhit", {511'd0, rdRespHit}, '0);
      check("rst_rddata", rdRespData, '0);
      check("rst_state", {510'd0, ctrlState}, '0);
      check("rst_errcnt", {480'd0, dupErrCnt, fullErrCnt}, '0);

      // Enable, then a single prefetch issue.
      crs_enable = 1'b1;
      @(negedge clk);
      check("state_run", {510'd0, ctrlState}, 512'd1);
      pfReqValid = 1'b1; pfReqAddr = 64'h1000;
      grant_step("g_pf_first", 4'b0001, 1'b1);
      @(negedge clk) pfReqValid = 1'b0;

      // All four channels at once, then READ/PF alternation.
      dramRespValid = 1'b1; dramRespAddr = 64'hA100; dramRespData = blk(64'hD0D0_1234);
      invValid = 1'b1; invAddr = 64'hB200;
      rdReqValid = 1'b1; rdReqAddr = 64'hC300;
      pfReqValid = 1'b1; pfReqAddr = 64'hE400;
      grant_step("g_wresp", 4'b1000, 1'b1);
      @(negedge clk) dramRespValid = 1'b0;
      grant_step("g_inv", 4'b0100, 1'b1);
      @(negedge clk) invValid = 1'b0;
      grant_step("g_rd0", 4'b0010, 1'b1);
      @(negedge clk);
      grant_step("g_pf0", 4'b0001, 1'b1);
      @(negedge clk);
      grant_step("g_rd1", 4'b0010, 1'b1);
      @(negedge clk);
      grant_step("g_pf1", 4'b0001, 1'b1);
      @(negedge clk) begin rdReqValid = 1'b0; pfReqValid = 1'b0; end
      repeat (3) @(negedge clk);

      // Outstanding limit including the WREQ currently on the port.
      crs_maxOutstanding = 7'd2; qOutstandingReqCnt = 7'd1;
      pfReqValid = 1'b1; pfReqAddr = 64'h2000;
      grant_step("g_pf_lim_ok", 4'b0001, 1'b1);
      @(negedge clk);
      #1 check("pf_blocked_wreq_on_port", {511'd0, pfReqReady}, '0);
      @(negedge clk) qOutstandingReqCnt = 7'd2;
      #1 check("pf_blocked_cnt2", {511'd0, pfReqReady}, '0);
      @(negedge clk) begin qOutstandingReqCnt = 7'd0; pfReqAddr = 64'h2040; end
      grant_step("g_pf_cnt0", 4'b0001, 1'b1);
      @(negedge clk) pfReqValid = 1'b0;
      crs_maxOutstanding = 7'd8;
      repeat (2) @(negedge clk);

      // Queue-full error on a WREQ: backoff, prefetch blocked, then back to RUN.
      err_q.push_back(2'd2);
      pfReqValid = 1'b1; pfReqAddr = 64'h3000;
      grant_step("g_pf_full", 4'b0001, 1'b1);
      @(negedge clk) pfReqValid = 1'b0;
      @(negedge clk);
      @(negedge clk) begin pfReqValid = 1'b1; pfReqAddr = 64'h3F00; end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         check("backoff_state", {510'd0, ctrlState}, 512'd2);
         check("backoff_pf_blocked", {511'd0, pfReqReady}, '0);
      end
      done = 1'b0;
      for (int i = 0; i < 6 && !done; i++) begin
         @(negedge clk);
         #1;
         if (ctrlState == 2'd1) begin
            pfReqValid = 1'b0;
            done = 1'b1;
         end
      end
      pfReqValid = 1'b0;
      check("backoff_exit", {511'd0, done}, 512'd1);
      check("full_cnt", {496'd0, fullErrCnt}, 512'd1);

      // Duplicate-address error counts but keeps RUN.
      @(negedge clk);
      err_q.push_back(2'd1);
      pfReqValid = 1'b1; pfReqAddr = 64'h3100;
      grant_step("g_pf_dup", 4'b0001, 1'b1);
      @(negedge clk) pfReqValid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("dup_cnt", {496'd0, dupErrCnt}, 512'd1);
      check("dup_state_run", {510'd0, ctrlState}, 512'd1);

      // Three back-to-back lookups, hits 1,0,1.
      @(negedge clk) begin rdReqValid = 1'b1; rdReqAddr = 64'h4000; end
      grant_step("g_rd_b0", 4'b0010, 1'b1);
      @(negedge clk) rdReqAddr = 64'h4040;
      grant_step("g_rd_b1", 4'b0010, 1'b0);
      @(negedge clk) rdReqAddr = 64'h4080;
      grant_step("g_rd_b2", 4'b0010, 1'b1);
      @(negedge clk) rdReqValid = 1'b0;
      #1 check("rd_pipe0", {511'd0, rdRespValid}, 512'd1);
      @(negedge clk);
      #1 check("rd_pipe1", {511'd0, rdRespValid}, 512'd1);
      @(negedge clk);
      #1 check("rd_pipe2", {511'd0, rdRespValid}, 512'd1);
      @(negedge clk);
      #1 check("rd_pipe_end", {511'd0, rdRespValid}, '0);

      // Drain: prefetch blocked, WRESP still accepted, DISABLED once count is 0.
      @(negedge clk) begin qOutstandingReqCnt = 7'd3; crs_enable = 1'b0; end
      @(negedge clk) begin pfReqValid = 1'b1; pfReqAddr = 64'h6000; end
      #1;
      check("drain_state", {510'd0, ctrlState}, 512'd3);
      check("drain_pf_blocked", {511'd0, pfReqReady}, '0);
      @(negedge clk) begin
         dramRespValid = 1'b1; dramRespAddr = 64'h6100; dramRespData = blk(64'h5A5A);
      end
      grant_step("g_drain_wresp", 4'b1000, 1'b1);
      @(negedge clk) begin
         dramRespValid = 1'b0; pfReqValid = 1'b0; qOutstandingReqCnt = 7'd0;
      end
      #1 check("drain_hold", {510'd0, ctrlState}, 512'd3);
      @(negedge clk);
      #1 check("disabled", {510'd0, ctrlState}, '0);

      // Reset while a lookup is in flight: it never returns.
      @(negedge clk) crs_enable = 1'b1;
      @(negedge clk) begin rdReqValid = 1'b1; rdReqAddr = 64'h5000; end
      #1 check("g_rd_reset", {511'd0, rdReqReady}, 512'd1);
      c.op = 3'd2; c.addr = 64'h5000; c.data = '0; c.chk_data = 1'b0;
      exp_cmd.push_back(c);
      @(negedge clk) rdReqValid = 1'b0;
      #2 resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 check("no_resp_after_reset", {511'd0, rdRespValid}, '0);
      end
      check("cmd_queue_empty", {480'd0, exp_cmd.size()}, '0);
      check("rd_queue_empty", {480'd0, exp_rd.size()}, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/prefetcher_queue_ctrl.md
# prefetcher_queue_ctrl

Front-end controller for the prefetcher data queue. It arbitrates four requester channels onto the queue's single registered opcode/address/data port: DRAM read-data responses, invalidates, CPU read lookups and prefetch issues. It also tracks the queue's delayed read response and error code, and throttles prefetch issue on occupancy and on "queue full" errors. It sits between the AXI-facing prefetch logic and the data queue.

## Interface
- LOG_QUEUE_SIZE, 6, log2 of queue depth
- LOG_BLOCK_DATA_BYTES, 6, log2 of block bytes; BLK_BITS = 8<<LOG_BLOCK_DATA_BYTES
- ADDR_BITS, 64, address width
- BACKOFF_BITS, 8, backoff counter width

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- dramRespValid / dramRespReady  in/out  1  DRAM data response handshake
- dramRespAddr / dramRespData  in  ADDR_BITS / BLK_BITS  response block address and data
- invValid / invReady  in/out  1  invalidate handshake; invAddr in ADDR_BITS
- rdReqValid / rdReqReady  in/out  1  CPU lookup handshake; rdReqAddr in ADDR_BITS
- rdRespValid  out  1  one-cycle pulse, lookup result
- rdRespHit  out  1  data present at the queue head
- rdRespData  out  BLK_BITS  looked-up block
- pfReqValid / pfReqReady  in/out  1  prefetch issue handshake; pfReqAddr in ADDR_BITS
- qReqAddr / qReqData / qReqOpcode  out  ADDR_BITS / BLK_BITS / 3  registered queue command
- qRespValid / qRespData  in  1 / BLK_BITS  queue read result
- qOutstandingReqCnt  in  LOG_QUEUE_SIZE+1  queue outstanding count
- qAlmostFull  in  1  queue almost-full flag
- qErrorCode  in  2  queue error code
- crs_enable  in  1  enables prefetching
- crs_maxOutstanding  in  LOG_QUEUE_SIZE+1  prefetch outstanding limit
- crs_backoffCycles  in  BACKOFF_BITS  backoff length after a full error
- ctrlState  out  2  FSM state
- dupErrCnt / fullErrCnt  out  16 each  saturating error counters

## Operation
- Opcodes: NOP=0, INV=1, READ=2, WREQ=3, WRESP=4. Error codes: 0 none, 1 duplicate address, 2 queue full.
- One grant per cycle. Readies are combinational and equal the grant.
  - Fixed priority: WRESP > INV > {READ, PF}.
  - READ and PF share a 2-way round-robin; the grant winner loses priority next time. After reset READ is favoured.
- Eligibility:
  - WRESP and INV: all states.
  - READ: RUN, BACKOFF, DRAIN.
  - PF: RUN only, with !qAlmostFull and effective outstanding < crs_maxOutstanding.
  - Effective outstanding = qOutstandingReqCnt + 1 if a WREQ is currently driven on the q outputs, else qOutstandingReqCnt. This compensates for the queue's 1-cycle count lag.
- Granted command is registered onto qReq*. The cycle after a no-grant edge drives NOP; addr and data hold their last values.
- Shift-register tag pipeline, 2 deep, records the opcode of each issued command.
- FSM states: DISABLED=0, RUN=1, BACKOFF=2, DRAIN=3.
  - DISABLED: crs_enable -> RUN.
  - RUN: !crs_enable -> DRAIN (takes priority). Sampled full error -> BACKOFF, counter loaded with crs_backoffCycles.
  - BACKOFF: counter decrements each cycle. Counter==0 -> RUN (a load of 0 returns next cycle). !crs_enable -> DRAIN.
  - DRAIN: crs_enable -> RUN. Otherwise, qOutstandingReqCnt==0 and no WREQ in the tag pipeline -> DISABLED.
- Errors sampled in any state increment their counter; both counters saturate at 0xFFFF.
- A full error sampled in DRAIN or DISABLED does not enter BACKOFF.

## Timing
- Handshake accepted at edge k:
  - Command is on qReq* from k to k+1.
  - Queue acts at edge k+1.
- READ accepted at edge k:
  - qRespData is captured at edge k+1 (address still driven).
  - qRespValid is captured at edge k+2.
  - rdRespValid=1 with hit and data in the cycle after k+2.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- WREQ accepted at edge k: qErrorCode is sampled at edge k+2 and attributed to that WREQ only.
- Reset values:
  - qReqOpcode=NOP, qReqAddr=0, qReqData=0.
  - rdRespValid=0, rdRespHit=0, rdRespData=0.
  - Pipeline cleared, counters 0, round-robin favours READ, state DISABLED.
  - All readies 0 while resetN is low.
- Reset mid-operation: in-flight reads are dropped and never return.

## Structure
- Package prefetcher_pkg holds:
  - opcode enum, error-code enum, FSM state enum;
  - BLK_BITS derivation as a constant function.
- One sub-module, prefetcher_rr_arb2: 2-requester round-robin arbiter with a registered pointer, instantiated for READ/PF.

## Test plan
- After reset, crs_enable=1; single pfReqAddr=0x1000 -> qReqOpcode=3, addr 0x1000 one cycle after accept; ctrlState=RUN.
- Same edge: dramRespValid, invValid, rdReqValid and pfReqValid all 1 -> order of grants is WRESP, INV, READ, PF. Then READ/PF alternate when both are held valid.
- crs_maxOutstanding=2, qOutstandingReqCnt=1, WREQ on outputs -> pfReqReady=0. It returns to 1 when the count drops to 0.
- qErrorCode=2 two edges after a WREQ, crs_backoffCycles=5 -> BACKOFF for 5 cycles, pfReqReady=0 throughout; fullErrCnt=1; then RUN.
- Three back-to-back reads with queue qRespValid pattern 1,0,1 -> rdRespValid on 3 consecutive cycles, hits 1,0,1, data matching each read address.
- crs_enable dropped with 3 outstanding -> DRAIN, PF blocked, WRESPs still accepted. Enters DISABLED one cycle after the count reaches 0. Reset asserted mid-read gives no rdRespValid.
